// File: rtl/cache_pkg.sv
// Shared types and default sizes for the direct-mapped write-through cache controller.
package cache_pkg;

   localparam int DEF_ADDR_WIDTH = 14;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_LINES      = 16;
   localparam int CNT_WIDTH      = 16;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      MEM_RD   = 3'd2,
      MEM_WAIT = 3'd3,
      MEM_WR   = 3'd4,
      RESP     = 3'd5
   } state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU request/response and RAM control bundle between the cache and its environment.
interface cache_ctrl_if
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   // Handshake: req is a strobe sampled only while the cache is IDLE (never queued);
   // ready is a one-cycle pulse, with rdata/hit valid only during that cycle.
   logic                  req;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  ready;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  hit;
   logic                  mem_cs;
   logic                  mem_we;
   logic                  mem_oe;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [CNT_WIDTH-1:0]  hit_count;
   logic [CNT_WIDTH-1:0]  miss_count;

   modport slave (
      input  req, req_we, req_addr, req_wdata, mem_rdata,
      output ready, rdata, hit, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata,
             hit_count, miss_count
   );

   modport master (
      output req, req_we, req_addr, req_wdata, mem_rdata,
      input  ready, rdata, hit, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata,
             hit_count, miss_count
   );

endinterface

// File: rtl/cache_line_array.sv
// Tag/data/valid storage: one async read port, one sync write port, valid bits cleared by reset.
module cache_line_array #(
   parameter int LINES      = 16,
   parameter int TAG_WIDTH  = 10,
   parameter int DATA_WIDTH = 16,
   localparam int IDX_W     = $clog2(LINES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output logic                  o_rd_valid,
   output logic [TAG_WIDTH-1:0]  o_rd_tag,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   input  logic                  i_wr_en,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [TAG_WIDTH-1:0]  i_wr_tag,
   input  logic [DATA_WIDTH-1:0] i_wr_data
);
   logic [LINES-1:0]      r_valid;
   logic [TAG_WIDTH-1:0]  r_tag  [LINES];
   logic [DATA_WIDTH-1:0] r_data [LINES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache controller.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LINES      = DEF_LINES
) (
   input  logic         clk,
   input  logic         reset,
   cache_ctrl_if.slave  bus,
   output state_t       o_state
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_WIDTH - IDX_W;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_hit;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [CNT_WIDTH-1:0]  r_hit_count;
   logic [CNT_WIDTH-1:0]  r_miss_count;

   logic [IDX_W-1:0]      w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_rd_valid;
   logic [TAG_W-1:0]      w_rd_tag;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_lookup_hit;
   logic                  w_wr_en;
   logic [DATA_WIDTH-1:0] w_wr_data;

   assign w_idx        = r_addr[IDX_W-1:0];
   assign w_tag        = r_addr[ADDR_WIDTH-1:IDX_W];
   assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);

   // Fill on load miss; on a store only refresh a line that already holds this address.
   assign w_wr_en   = (r_state == MEM_WAIT) || ((r_state == MEM_WR) && r_hit);
   assign w_wr_data = (r_state == MEM_WAIT) ? bus.mem_rdata : r_wdata;

   cache_line_array #(
      .LINES      (LINES),
      .TAG_WIDTH  (TAG_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lines (
      .clk        (clk),
      .reset      (reset),
      .i_rd_idx   (w_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (w_idx),
      .i_wr_tag   (w_tag),
      .i_wr_data  (w_wr_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (bus.req) w_next_state = LOOKUP;
         LOOKUP: begin
            if (r_we)              w_next_state = MEM_WR;
            else if (w_lookup_hit) w_next_state = RESP;
            else                   w_next_state = MEM_RD;
         end
         MEM_RD:   w_next_state = MEM_WAIT;
         MEM_WAIT: w_next_state = RESP;
         MEM_WR:   w_next_state = RESP;
         RESP:     w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_cs     = (r_state == MEM_RD) || (r_state == MEM_WR);
      bus.mem_oe     = (r_state == MEM_RD);
      bus.mem_we     = (r_state == MEM_WR);
      bus.mem_addr   = bus.mem_cs ? r_addr : '0;
      bus.mem_wdata  = (r_state == MEM_WR) ? r_wdata : '0;
      bus.ready      = (r_state == RESP);
      bus.hit        = (r_state == RESP) && r_hit;
      bus.rdata      = r_rdata;
      bus.hit_count  = r_hit_count;
      bus.miss_count = r_miss_count;
      o_state        = r_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_hit        <= 1'b0;
         r_rdata      <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req) begin
                  r_addr  <= bus.req_addr;
                  r_we    <= bus.req_we;
                  r_wdata <= bus.req_wdata;
               end
            end
            LOOKUP: begin
               r_hit <= w_lookup_hit;
               if (!r_we && w_lookup_hit) r_rdata <= w_rd_data;
            end
            MEM_WAIT: r_rdata <= bus.mem_rdata;
            RESP: begin
               if (r_hit) begin
                  if (r_hit_count != CNT_MAX) r_hit_count <= r_hit_count + 1'b1;
               end else begin
                  if (r_miss_count != CNT_MAX) r_miss_count <= r_miss_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: vector table of accesses plus reset-abort and ignored-req sequences.
module tb_cache_ctrl;
   import cache_pkg::*;

   logic   clk;
   logic   reset;
   state_t dbg_state;
   int     n_checks;
   int     n_errors;

   cache_ctrl_if #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) bus ();

   cache_ctrl #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .LINES(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .o_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM model; preset contents are reloaded while reset is held.
   logic [15:0] ram [0:16383];
   always @(posedge clk) begin
      if (reset) begin
         ram[14'h10B] <= 16'h0005;
         ram[14'h11B] <= 16'hFFFF;
         ram[14'h10C] <= 16'h1234;
      end else if (bus.mem_cs) begin
         if (bus.mem_oe) bus.mem_rdata <= ram[bus.mem_addr];
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   int          rd_total;
   int          wr_total;
   int          bad_total;
   logic [13:0] last_rd_addr;
   logic [13:0] last_wr_addr;
   logic [15:0] last_wr_data;
   initial begin
      rd_total = 0; wr_total = 0; bad_total = 0;
      last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
   end
   always @(negedge clk) begin
      if (bus.mem_cs && bus.mem_oe && !bus.mem_we) begin
         rd_total++;
         last_rd_addr = bus.mem_addr;
      end
      if (bus.mem_cs && bus.mem_we && !bus.mem_oe) begin
         wr_total++;
         last_wr_addr = bus.mem_addr;
         last_wr_data = bus.mem_wdata;
      end
      if ((!bus.mem_cs && (bus.mem_we || bus.mem_oe)) || (bus.mem_we && bus.mem_oe)) bad_total++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One access; cyc counts cycles with the req-sampling cycle as cycle 0.
   task automatic run_access(input logic we, input logic [13:0] addr, input logic [15:0] wd,
                             input logic poke, output logic [15:0] rd, output logic h,
                             output int cyc);
      bit done;
      @(posedge clk);
      #1;
      bus.req = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk);
      #1 bus.req = poke;
      cyc = 1; done = 0; rd = '0; h = 1'b0;
      while (!done && cyc <= 20) begin
         @(negedge clk);
         if (bus.ready) begin
            done = 1;
            rd   = bus.rdata;
            h    = bus.hit;
         end else begin
            @(posedge clk);
            #1 bus.req = 1'b0;
            cyc++;
         end
      end
      bus.req = 1'b0;
   endtask

   typedef struct {
      bit          rst;
      logic        we;
      logic [13:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      logic        exp_hit;
      int          exp_cyc;
      int          exp_rd;
      int          exp_wr;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [15:0] rd;
      logic        h;
      int          cyc;
      int          rd0, wr0, bad0, rdy_seen, cs_seen;
      bit          found;

      n_checks = 0; n_errors = 0;
      reset = 1'b1;
      bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.mem_rdata = '0;

      //        rst we  addr      wdata     rdata     hit cyc rd wr hits miss
      vecs[0] = '{0, 0, 14'h10B, 16'h0000, 16'h0005, 0, 4, 1, 0, 0, 1};
      vecs[1] = '{0, 0, 14'h10B, 16'h0000, 16'h0005, 1, 2, 0, 0, 1, 1};
      vecs[2] = '{0, 1, 14'h10B, 16'h0023, 16'h0000, 1, 3, 0, 1, 2, 1};
      vecs[3] = '{0, 0, 14'h10B, 16'h0000, 16'h0023, 1, 2, 0, 0, 3, 1};
      vecs[4] = '{0, 1, 14'h10D, 16'h00FF, 16'h0000, 0, 3, 0, 1, 3, 2};
      vecs[5] = '{0, 0, 14'h10D, 16'h0000, 16'h00FF, 0, 4, 1, 0, 3, 3};
      vecs[6] = '{1, 0, 14'h10B, 16'h0000, 16'h0005, 0, 4, 1, 0, 0, 1};
      vecs[7] = '{0, 0, 14'h11B, 16'h0000, 16'hFFFF, 0, 4, 1, 0, 0, 2};
      vecs[8] = '{0, 0, 14'h10B, 16'h0000, 16'h0005, 0, 4, 1, 0, 0, 3};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_hit", 32'(bus.hit), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_mem_ctl", {29'd0, bus.mem_cs, bus.mem_we, bus.mem_oe}, 32'd0);
      chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
      chk("rst_counts", {bus.hit_count, bus.miss_count}, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].rst) do_reset();
         rd0 = rd_total; wr0 = wr_total; bad0 = bad_total;
         run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd, h, cyc);
         chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         chk($sformatf("v%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
         if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
         @(negedge clk);
         chk($sformatf("v%0d_ready_pulse", i), 32'(bus.ready), 32'd0);
         chk($sformatf("v%0d_rd_strobes", i), 32'(rd_total - rd0), 32'(vecs[i].exp_rd));
         chk($sformatf("v%0d_wr_strobes", i), 32'(wr_total - wr0), 32'(vecs[i].exp_wr));
         chk($sformatf("v%0d_bad_strobes", i), 32'(bad_total - bad0), 32'd0);
         if (vecs[i].exp_rd != 0) chk($sformatf("v%0d_rd_addr", i), 32'(last_rd_addr), 32'(vecs[i].addr));
         if (vecs[i].we) begin
            chk($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_wr_data", i), 32'(last_wr_data), 32'(vecs[i].wdata));
         end
         chk($sformatf("v%0d_hit_count", i), 32'(bus.hit_count), 32'(vecs[i].exp_hits));
         chk($sformatf("v%0d_miss_count", i), 32'(bus.miss_count), 32'(vecs[i].exp_misses));
      end

      // req held high into LOOKUP must not start a second access.
      rd0 = rd_total;
      run_access(1'b0, 14'h10B, 16'h0000, 1'b1, rd, h, cyc);
      chk("ign_cycles", 32'(cyc), 32'd2);
      chk("ign_hit", 32'(h), 32'd1);
      chk("ign_rdata", 32'(rd), 32'h0005);
      rdy_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.ready) rdy_seen++;
      end
      chk("ign_extra_ready", 32'(rdy_seen), 32'd0);
      chk("ign_rd_strobes", 32'(rd_total - rd0), 32'd0);
      chk("ign_hit_count", 32'(bus.hit_count), 32'd1);
      chk("ign_miss_count", 32'(bus.miss_count), 32'd3);

      // Reset while waiting on the RAM: no fill, no ready, no further strobes.
      @(posedge clk);
      #1;
      bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 14'h10C; bus.req_wdata = '0;
      @(posedge clk);
      #1 bus.req = 1'b0;
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (dbg_state == MEM_WAIT) found = 1;
      end
      chk("abort_reached_mem_wait", 32'(found), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_state", 32'(dbg_state), 32'(IDLE));
      chk("abort_ready", 32'(bus.ready), 32'd0);
      chk("abort_rdata", 32'(bus.rdata), 32'd0);
      chk("abort_counts", {bus.hit_count, bus.miss_count}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      rdy_seen = 0; cs_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.ready) rdy_seen++;
         if (bus.mem_cs) cs_seen++;
      end
      chk("abort_no_ready", 32'(rdy_seen), 32'd0);
      chk("abort_no_strobe", 32'(cs_seen), 32'd0);
      rd0 = rd_total;
      run_access(1'b0, 14'h10C, 16'h0000, 1'b0, rd, h, cyc);
      chk("post_abort_cycles", 32'(cyc), 32'd4);
      chk("post_abort_hit", 32'(h), 32'd0);
      chk("post_abort_rdata", 32'(rd), 32'h1234);
      @(negedge clk);
      chk("post_abort_rd_strobes", 32'(rd_total - rd0), 32'd1);
      chk("post_abort_miss_count", 32'(bus.miss_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width.
REQ-003 SHALL have parameter LINES, default 16, direct-mapped line count (power of 2), one word per line.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  CPU request strobe, sampled only in IDLE.
REQ-007 req_we  input  1  1=store, 0=load.
REQ-008 req_addr  input  ADDR_WIDTH  CPU word address.
REQ-009 req_wdata  input  DATA_WIDTH  store data.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 rdata  output  DATA_WIDTH  load data, valid while ready=1 for a load.
REQ-012 hit  output  1  valid with ready; 1 if the access hit.
REQ-013 mem_cs, mem_we, mem_oe  output  1 each  controls to the single-port sync RAM.
REQ-014 mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH; mem_rdata  input  DATA_WIDTH.
REQ-015 hit_count, miss_count  output  16 each  saturating access statistics.

Function
REQ-016 States SHALL be IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR, RESP.
REQ-017 IDLE: req=1 -> latch addr/we/wdata, go LOOKUP; req=0 -> stay.
REQ-018 Index = addr[log2(LINES)-1:0]; tag = remaining upper bits; hit = valid[index] && tag match.
REQ-019 LOOKUP, load hit -> RESP with rdata = line data; ready occurs 2 cycles after req sample.
REQ-020 LOOKUP, load miss -> MEM_RD: mem_cs=1, mem_oe=1, mem_we=0, mem_addr=latched addr for exactly one cycle.
REQ-021 MEM_WAIT: capture mem_rdata, fill line (data, tag, valid=1), go RESP; load-miss ready 4 cycles after req sample.
REQ-022 LOOKUP, store (hit or miss) -> MEM_WR: mem_cs=1, mem_we=1, mem_oe=0, mem_wdata=latched wdata for one cycle (write-through).
REQ-023 Store hit SHALL update line data in MEM_WR; store miss SHALL NOT allocate (no-write-allocate).
REQ-024 Store ready SHALL occur 3 cycles after req sample; rdata don't-care for stores.
REQ-025 RESP: ready=1 and hit valid for one cycle, then IDLE unconditionally; next req sampled no earlier than the following cycle.
REQ-026 req asserted in any state other than IDLE SHALL be ignored (not queued).
REQ-027 Outside MEM_RD/MEM_WR, mem_cs=0, mem_we=0, mem_oe=0.
REQ-028 hit_count/miss_count SHALL increment in RESP per access and hold at 0xFFFF.
REQ-029 Same-index different-tag load miss SHALL evict the resident line (no dirty state exists).

Reset
REQ-030 reset=1 SHALL immediately force IDLE, all valid bits 0, ready=0, hit=0, rdata=0, mem_* outputs 0, counters 0.
REQ-031 Reset mid-transaction SHALL abort it: no line fill, no ready pulse, no further memory strobes.
REQ-032 Tag/data arrays need not be reset; only valid bits.

Structure
REQ-033 State enum and default widths SHALL live in shared package cache_pkg.
REQ-034 Tag/data/valid storage SHALL be one sub-module cache_line_array (1 read, 1 write port, async valid clear).

Verification
REQ-035 Reset, load 0x10B with RAM[0x10B]=0x0005 -> miss, ready at cycle 4, rdata=0x0005, miss_count=1.
REQ-036 Repeat load 0x10B -> hit, ready at cycle 2, rdata=0x0005, no mem_cs pulse, hit_count=1.
REQ-037 Store 0x0023 to 0x10B -> one mem_we pulse addr 0x10B data 0x0023; next load 0x10B hits with 0x0023.
REQ-038 Store 0x00FF to 0x10D (not cached), then load 0x10D -> store miss no allocate; load misses, returns 0x00FF.
REQ-039 Load 0x10B then 0x11B (same index, RAM 0xFFFF) then 0x10B -> miss, miss, miss; rdata 0x0005, 0xFFFF, 0x0005.
REQ-040 Assert reset during MEM_WAIT of load 0x10C -> no ready; subsequent load 0x10C misses.
